branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Producer side of the branch-predictor update interface.
- Accepts up to two resolved branches per cycle from the execute/commit stage and detects mispredictions.
- On a misprediction, issues a registered flush/redirect to fetch.
- Buffers predictor training records in a small FIFO and drains one per cycle onto the predictor's branch_pc/branch_npc/actual_result/predict_update port.
- Keeps saturating branch and mispredict counters for performance debug.

Parameters:
- QDEPTH, 4, update FIFO entries; power of two, minimum 2.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low (already decided).
- a_valid  in  1  resolution port A valid; A is older than B.
- a_pc  in  32  PC of branch A.
- a_target  in  32  computed target of A.
- a_taken  in  1  actual direction of A.
- a_pred_pc  in  32  next-fetch PC the front end used after A.
- b_valid, b_pc, b_target, b_taken, b_pred_pc  in  1/32/32/1/32  same fields for younger branch B.
- res_ready  out  1  both ports may be presented this cycle.
- flush  out  1  one-cycle mispredict pulse.
- redirect_pc  out  32  correct next PC; valid when flush=1.
- branch_pc  out  32  predictor update PC (FIFO head).
- branch_npc  out  32  predictor update target.
- actual_result  out  1  predictor update direction.
- predict_update  out  1  head valid; the predictor consumes it every cycle.
- cnt_branch  out  CNT_W  accepted (non-squashed) branches.
- cnt_mispred  out  CNT_W  mispredictions.

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO emptied. All outputs 0 except res_ready=1.
- A port is accepted when its valid and res_ready are both 1.
- res_ready = (free FIFO slots >= 2). It is computed from registered count only, with no combinational path from inputs.
- Per accepted port X:
  - actual_npc = X_taken ? X_target : X_pc+4, 32-bit wrap.
  - mispred_X = (actual_npc != X_pred_pc).
- Priority rules:
  - If A is accepted and mispredicts, B is wrong-path and squashed: not enqueued, not counted, cannot redirect.
  - If A is correct or absent and B mispredicts, redirect goes to B's actual_npc.
  - At most one flush per cycle.
- Flush latency: accept at edge N → flush=1 and redirect_pc=actual_npc during cycle N+1, then flush=0 unless a new mispredict is accepted at edge N+1.
  - redirect_pc holds its last value when flush=0.
- Enqueue: every accepted, non-squashed branch is written as {pc, target, taken}.
  - Ordering is A then B; 0, 1 or 2 writes per cycle.
  - Not-taken entries are also enqueued so the BHT can decrement.
  - The target field carries a_target even when not taken.
- Dequeue:
  - predict_update = (count != 0).
  - branch_pc, branch_npc and actual_result are driven from head storage, with no combinational path from res inputs.
  - The head pops at every edge where predict_update=1.
  - Empty queue: accept at edge N → the entry is visible in cycle N+1 and popped at edge N+1. A second entry accepted at the same edge is visible in cycle N+2.
- Simultaneous push and pop: count_next = count + pushes − pop. Pointers wrap modulo QDEPTH.
- Full queue cannot overflow, because ready requires 2 free slots.
- Counters:
  - cnt_branch increments by 0/1/2 per cycle.
  - cnt_mispred increments by 0/1.
  - Both saturate at 2^CNT_W−1.
- Valid asserted while res_ready=0: the input is ignored. The upstream must hold it.
- Reset mid-operation: queued updates are discarded, and a pending flush pulse is cancelled immediately.

Decomposition:
- Shared config package/header: InstAddrBus width (32), the True/False constants, and the update-record layout {pc[31:0], npc[31:0], taken}.
- Natural sub-module: branch_update_fifo (QDEPTH entries, 2 write ports, 1 read port, registered count). It is reusable wherever the predictor port is shared.

Test Plan:
- Reset, then idle: predict_update=0, flush=0, res_ready=1, counters 0.
- Port A only: pc=0x100, taken=1, target=0x200, pred_pc=0x200.
  - No flush.
  - Next cycle: predict_update=1, branch_pc=0x100, branch_npc=0x200, actual_result=1.
  - cnt_branch=1.
- Port A: pc=0x100, taken=0, pred_pc=0x200.
  - Next cycle: flush=1, redirect_pc=0x104, cnt_mispred=1.
  - Update entry has actual_result=0.
- A mispredicts (pc=0x40, taken=1, target=0x80, pred_pc=0x44) together with valid B (pc=0x44):
  - Only A is enqueued; redirect_pc=0x80.
  - cnt_branch=1 and no second update appears.
- A correct and B (pc=0x300, taken=1, target=0x500, pred_pc=0x304) in the same cycle:
  - Both updates are drained in order on consecutive cycles (A then B).
  - flush redirects to 0x500.
- Both ports valid every cycle with QDEPTH=4:
  - res_ready drops when count=3.
  - No entry is lost or duplicated and ordering is preserved across pointer wrap.
  - Asserting rst_n=0 mid-stream empties the queue and clears flush asynchronously.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared types for the branch resolution / predictor update path.
// Holds the instruction address width, boolean constants and the update record layout.
package branch_resolve_pkg;

    localparam int INST_ADDR_W = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;

    // One predictor training record: {pc, npc (branch target), taken}.
    typedef struct packed {
        inst_addr_t pc;
        inst_addr_t npc;
        logic       taken;
    } upd_rec_t;

    localparam int UPD_REC_W = $bits(upd_rec_t);

    function automatic inst_addr_t actual_npc(input inst_addr_t pc,
                                              input inst_addr_t target,
                                              input logic       taken);
        return taken ? target : pc + INST_ADDR_W'(4);
    endfunction

    function automatic upd_rec_t make_rec(input inst_addr_t pc,
                                          input inst_addr_t target,
                                          input logic       taken);
        upd_rec_t r;
        r.pc    = pc;
        r.npc   = target;
        r.taken = taken;
        return r;
    endfunction

endpackage

// File: rtl/branch_update_fifo.sv
// Predictor update queue: two write ports (slot 0 is older), one read port.
// The head is popped on every edge where the queue is non-empty.
module branch_update_fifo
    import branch_resolve_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     wr0_en,
    input  upd_rec_t wr0_rec,
    input  logic     wr1_en,
    input  upd_rec_t wr1_rec,
    output upd_rec_t head_rec,
    output logic     head_valid,
    output logic     two_free
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW    = PTR_W + 1;

    upd_rec_t         mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    count_q;

    logic [PTR_W-1:0] wr1_idx;
    logic [CW-1:0]    num_push;
    logic             pop;

    always_comb begin
        wr1_idx  = wr_ptr + PTR_W'(wr0_en);
        num_push = CW'(wr0_en) + CW'(wr1_en);
        pop      = (count_q != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PTR_W'(num_push);
            rd_ptr  <= rd_ptr + PTR_W'(pop);
            count_q <= count_q + num_push - CW'(pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr_ptr]  <= wr0_rec;
        if (wr1_en) mem[wr1_idx] <= wr1_rec;
    end

    always_comb begin
        head_valid = pop;
        head_rec   = pop ? mem[rd_ptr] : '0;
        two_free   = (count_q <= CW'(QDEPTH - 2));
    end

endmodule

// File: rtl/branch_resolve.sv
// Accepts up to two resolved branches per cycle, raises a registered flush on
// mispredict, queues predictor training records and keeps perf counters.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [31:0]       a_pc,
    input  logic [31:0]       a_target,
    input  logic              a_taken,
    input  logic [31:0]       a_pred_pc,
    input  logic              b_valid,
    input  logic [31:0]       b_pc,
    input  logic [31:0]       b_target,
    input  logic              b_taken,
    input  logic [31:0]       b_pred_pc,
    output logic              res_ready,
    output logic              flush,
    output logic [31:0]       redirect_pc,
    output logic [31:0]       branch_pc,
    output logic [31:0]       branch_npc,
    output logic              actual_result,
    output logic              predict_update,
    output logic [CNT_W-1:0]  cnt_branch,
    output logic [CNT_W-1:0]  cnt_mispred
);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] s;
        s = {1'b0, v} + (CNT_W+1)'(inc);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    inst_addr_t a_npc, b_npc;
    logic       a_acc, b_acc, a_mis, b_mis;
    upd_rec_t   a_rec, b_rec;
    logic       wr0_en, wr1_en;
    upd_rec_t   wr0_rec, wr1_rec;
    upd_rec_t   head_rec;
    logic       two_free;

    always_comb begin
        a_npc = actual_npc(a_pc, a_target, a_taken);
        b_npc = actual_npc(b_pc, b_target, b_taken);
        a_acc = a_valid & res_ready;
        a_mis = a_acc & (a_npc != a_pred_pc);
        // A mispredict puts B on the wrong path: it is dropped entirely.
        b_acc = b_valid & res_ready & ~a_mis;
        b_mis = b_acc & (b_npc != b_pred_pc);

        a_rec = make_rec(a_pc, a_target, a_taken);
        b_rec = make_rec(b_pc, b_target, b_taken);

        // Compact writes so the older accepted record always lands in slot 0.
        wr0_en  = a_acc | b_acc;
        wr0_rec = a_acc ? a_rec : b_rec;
        wr1_en  = a_acc & b_acc;
        wr1_rec = b_rec;
    end

    branch_update_fifo #(
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr0_en     (wr0_en),
        .wr0_rec    (wr0_rec),
        .wr1_en     (wr1_en),
        .wr1_rec    (wr1_rec),
        .head_rec   (head_rec),
        .head_valid (predict_update),
        .two_free   (two_free)
    );

    always_comb begin
        res_ready     = two_free;
        branch_pc     = head_rec.pc;
        branch_npc    = head_rec.npc;
        actual_result = head_rec.taken;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush       <= FALSE;
            redirect_pc <= '0;
            cnt_branch  <= '0;
            cnt_mispred <= '0;
        end else begin
            flush <= a_mis | b_mis;
            if (a_mis) begin
                redirect_pc <= a_npc;
            end else if (b_mis) begin
                redirect_pc <= b_npc;
            end
            cnt_branch  <= sat_add(cnt_branch, {1'b0, a_acc} + {1'b0, b_acc});
            cnt_mispred <= sat_add(cnt_mispred, {1'b0, a_mis | b_mis});
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: queue-based reference model plus directed vectors.
module tb_branch_resolve;

    localparam int QDEPTH = 4;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_valid, b_valid;
    logic [31:0]       a_pc, a_target, a_pred_pc;
    logic [31:0]       b_pc, b_target, b_pred_pc;
    logic              a_taken, b_taken;
    logic              res_ready, flush, actual_result, predict_update;
    logic [31:0]       redirect_pc, branch_pc, branch_npc;
    logic [CNT_W-1:0]  cnt_branch, cnt_mispred;

    always #5 clk = ~clk;

    branch_resolve #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .a_valid        (a_valid),
        .a_pc           (a_pc),
        .a_target       (a_target),
        .a_taken        (a_taken),
        .a_pred_pc      (a_pred_pc),
        .b_valid        (b_valid),
        .b_pc           (b_pc),
        .b_target       (b_target),
        .b_taken        (b_taken),
        .b_pred_pc      (b_pred_pc),
        .res_ready      (res_ready),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .branch_pc      (branch_pc),
        .branch_npc     (branch_npc),
        .actual_result  (actual_result),
        .predict_update (predict_update),
        .cnt_branch     (cnt_branch),
        .cnt_mispred    (cnt_mispred)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        tk;
    } rec_t;

    rec_t        exp_q[$];
    logic        m_flush;
    logic [31:0] m_redirect;
    longint      m_cnt_br, m_cnt_mp;
    bit          check_en = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_npc(input logic [31:0] pc, input logic [31:0] tgt,
                                            input logic tk);
        return tk ? tgt : pc + 32'd4;
    endfunction

    function automatic longint sat(input longint v, input int inc);
        longint mx;
        mx = (longint'(1) << CNT_W) - 1;
        return (v + inc > mx) ? mx : v + inc;
    endfunction

    function automatic bit m_ready();
        return (QDEPTH - exp_q.size()) >= 2;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_flush    = 1'b0;
        m_redirect = '0;
        m_cnt_br   = 0;
        m_cnt_mp   = 0;
    endtask

    // Per-cycle comparison of every output against the reference model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("res_ready", res_ready, m_ready());
            chk("predict_update", predict_update, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("branch_pc", branch_pc, exp_q[0].pc);
                chk("branch_npc", branch_npc, exp_q[0].npc);
                chk("actual_result", actual_result, exp_q[0].tk);
            end
            chk("flush", flush, m_flush);
            chk("redirect_pc", redirect_pc, m_redirect);
            chk("cnt_branch", cnt_branch, m_cnt_br);
            chk("cnt_mispred", cnt_mispred, m_cnt_mp);
        end
    end

    // Advance one clock; model consumes the inputs presented before the edge.
    task automatic tick(output bit acc_a, output bit acc_b);
        bit          rdy, mis_a, mis_b;
        logic [31:0] na, nb;
        rec_t        ra, rb;
        rdy   = m_ready();
        na    = exp_npc(a_pc, a_target, a_taken);
        nb    = exp_npc(b_pc, b_target, b_taken);
        acc_a = a_valid && rdy;
        mis_a = acc_a && (na != a_pred_pc);
        acc_b = b_valid && rdy && !mis_a;
        mis_b = acc_b && (nb != b_pred_pc);
        ra    = '{a_pc, a_target, a_taken};
        rb    = '{b_pc, b_target, b_taken};
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) exp_q.delete(0);
        if (acc_a) exp_q.push_back(ra);
        if (acc_b) exp_q.push_back(rb);
        m_flush = mis_a || mis_b;
        if (mis_a) m_redirect = na;
        else if (mis_b) m_redirect = nb;
        m_cnt_br = sat(m_cnt_br, int'(acc_a) + int'(acc_b));
        m_cnt_mp = sat(m_cnt_mp, (mis_a || mis_b) ? 1 : 0);
    endtask

    task automatic tick_n(input int n);
        bit x, y;
        for (int k = 0; k < n; k++) tick(x, y);
    endtask

    task automatic drive_a(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic tk, input logic [31:0] pred);
        a_valid = v; a_pc = pc; a_target = tgt; a_taken = tk; a_pred_pc = pred;
    endtask

    task automatic drive_b(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic tk, input logic [31:0] pred);
        b_valid = v; b_pc = pc; b_target = tgt; b_taken = tk; b_pred_pc = pred;
    endtask

    task automatic idle();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic set_pair(input int i);
        logic [31:0] pa, pb, ta, tb;
        logic        tka;
        pa  = 32'h1000 + 32'(i * 8);
        pb  = pa + 32'd4;
        ta  = pa + 32'h40;
        tb  = 32'h2000 + 32'(i * 16);
        tka = (i % 2) == 1;
        drive_a(1'b1, pa, ta, tka, (i % 7 == 6) ? pa + 32'h100 : exp_npc(pa, ta, tka));
        drive_b(1'b1, pb, tb, 1'b1, (i % 5 == 3) ? pb + 32'd4 : tb);
    endtask

    initial begin
        bit aa, ab, seen_nr;
        int i, cyc;

        drive_a(1'b0, '0, '0, 1'b0, '0);
        drive_b(1'b0, '0, '0, 1'b0, '0);
        rst_n = 1'b0;
        model_clear();
        check_en = 1'b1;
        #23;
        chk("rst_res_ready", res_ready, 1);
        chk("rst_predict_update", predict_update, 0);
        chk("rst_flush", flush, 0);
        chk("rst_branch_pc", branch_pc, 0);
        chk("rst_cnt_branch", cnt_branch, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick_n(2);

        // A only, correctly predicted taken branch
        drive_a(1'b1, 32'h100, 32'h200, 1'b1, 32'h200);
        tick(aa, ab);
        idle();
        chk("a_only_flush", flush, 0);
        chk("a_only_upd", predict_update, 1);
        chk("a_only_pc", branch_pc, 32'h100);
        chk("a_only_npc", branch_npc, 32'h200);
        chk("a_only_dir", actual_result, 1);
        chk("a_only_cnt", cnt_branch, 1);
        tick_n(1);
        chk("a_only_drained", predict_update, 0);

        // A not taken, predicted taken
        drive_a(1'b1, 32'h100, 32'h200, 1'b0, 32'h200);
        tick(aa, ab);
        idle();
        chk("a_mis_flush", flush, 1);
        chk("a_mis_redirect", redirect_pc, 32'h104);
        chk("a_mis_cnt", cnt_mispred, 1);
        chk("a_mis_dir", actual_result, 0);
        chk("a_mis_npc", branch_npc, 32'h200);
        tick_n(1);
        chk("a_mis_pulse_end", flush, 0);
        chk("a_mis_hold", redirect_pc, 32'h104);

        // A mispredicts, B squashed
        drive_a(1'b1, 32'h40, 32'h80, 1'b1, 32'h44);
        drive_b(1'b1, 32'h44, 32'h90, 1'b0, 32'h48);
        tick(aa, ab);
        idle();
        chk("squash_redirect", redirect_pc, 32'h80);
        chk("squash_pc", branch_pc, 32'h40);
        chk("squash_cnt_br", cnt_branch, 3);
        chk("squash_cnt_mp", cnt_mispred, 2);
        tick_n(1);
        chk("squash_no_b", predict_update, 0);

        // A correct, B mispredicts
        drive_a(1'b1, 32'h200, 32'h280, 1'b0, 32'h204);
        drive_b(1'b1, 32'h300, 32'h500, 1'b1, 32'h304);
        tick(aa, ab);
        idle();
        chk("b_mis_flush", flush, 1);
        chk("b_mis_redirect", redirect_pc, 32'h500);
        chk("b_mis_first_pc", branch_pc, 32'h200);
        tick_n(1);
        chk("b_mis_second_pc", branch_pc, 32'h300);
        chk("b_mis_second_npc", branch_npc, 32'h500);
        chk("b_mis_cnt_br", cnt_branch, 5);
        chk("b_mis_cnt_mp", cnt_mispred, 3);
        tick_n(1);

        // Sustained dual issue with back-pressure and pointer wrap
        i = 0; cyc = 0; seen_nr = 1'b0;
        while (i < 24 && cyc < 200) begin
            set_pair(i);
            tick(aa, ab);
            if (!res_ready) seen_nr = 1'b1;
            if (aa) i++;
            cyc++;
        end
        chk("stream_done", i, 24);
        chk("stream_backpressure", seen_nr, 1);

        // Reset while a flush is pending and the queue is occupied
        drive_a(1'b1, 32'h5000, 32'h6000, 1'b1, 32'h5004);
        drive_b(1'b1, 32'h5004, 32'h7000, 1'b1, 32'h7000);
        cyc = 0; aa = 1'b0;
        while (!aa && cyc < 10) begin
            tick(aa, ab);
            cyc++;
        end
        idle();
        chk("pre_rst_accept", aa, 1);
        chk("pre_rst_flush", flush, 1);
        chk("pre_rst_redirect", redirect_pc, 32'h6000);
        chk("pre_rst_upd", predict_update, 1);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("mid_rst_flush", flush, 0);
        chk("mid_rst_upd", predict_update, 0);
        chk("mid_rst_ready", res_ready, 1);
        chk("mid_rst_cnt", cnt_branch, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick_n(2);

        drive_a(1'b1, 32'h800, 32'h900, 1'b1, 32'h900);
        tick(aa, ab);
        idle();
        chk("post_rst_pc", branch_pc, 32'h800);
        chk("post_rst_cnt", cnt_branch, 1);
        tick_n(2);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
